// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode and FSM state encodings shared by the shared-ALU arbiter
package ula_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/ula_core.sv
// rtl/ula_core.sv - combinational ALU: add, sub, shift-left, nand with carry/borrow
module ula_core #(
    parameter int W = 8
) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         carry
);
    import ula_pkg::*;

    // W+1-bit result: the top bit is carry, borrow, or the last bit shifted out.
    // Shifting the zero-extended operand gives carry=a[0] at b==W and zero beyond.
    logic [W:0] ext;

    always_comb begin
        ext = '0;
        case (op)
            OP_ADD:  ext = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext = {1'b0, a} - {1'b0, b};
            OP_SHL:  ext = {1'b0, a} << b;
            default: ext = {1'b0, ~(a & b)};
        endcase
        r     = ext[W-1:0];
        carry = ext[W];
    end

endmodule

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin arbiter sharing one ALU among NREQ requesters
module ula_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_carry,
    output logic              rsp_zero,
    output logic              busy
);
    import ula_pkg::*;

    logic [1:0]      state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  lat_id;
    logic [1:0]      lat_op;
    logic [W-1:0]    lat_a;
    logic [W-1:0]    lat_b;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            accept;
    logic [W-1:0]    alu_r;
    logic            alu_carry;

    // Scan from start downwards in priority so the closest requester at or after start wins.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [IDW-1:0]  start);
        logic [NREQ-1:0] pick;
        int idx;
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NREQ;
            if (valid[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        grant    = rr_pick(req_valid, ptr);
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = IDW'(i);
        end
    end

    assign accept    = (state == ST_IDLE) && (|req_valid);
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    ula_core #(.W(W)) u_core (
        .op    (lat_op),
        .a     (lat_a),
        .b     (lat_b),
        .r     (alu_r),
        .carry (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            lat_id    <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            rsp_id    <= '0;
            rsp_r     <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_id <= grant_id;
                        lat_op <= req_op[2*int'(grant_id) +: 2];
                        lat_a  <= req_a[W*int'(grant_id) +: W];
                        lat_b  <= req_b[W*int'(grant_id) +: W];
                        ptr    <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_id    <= lat_id;
                    rsp_r     <= alu_r;
                    rsp_carry <= alu_carry;
                    rsp_zero  <= (alu_r == '0);
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - directed self-checking bench for ula_arbiter
module tb_ula_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_r;
    logic              rsp_carry;
    logic              rsp_zero;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    ula_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got valid/busy/ready=%b%b/%b want 0/0/0000", rsp_valid, busy, req_ready);
        end
        vectors++;
        if ({rsp_id, rsp_r, rsp_carry, rsp_zero} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_rsp: got id=%h r=%h c=%b z=%b want all 0", rsp_id, rsp_r, rsp_carry, rsp_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_op(input int id, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                           input logic ez, input string nm);
        logic [W+IDW+2:0] got;
        logic [W+IDW+2:0] exp;
        @(negedge clk);
        req_valid              = NREQ'(1) << id;
        req_op[2*id +: 2]      = op;
        req_a[W*id +: W]       = a;
        req_b[W*id +: W]       = b;
        #1;
        vectors++;
        if (req_ready !== (NREQ'(1) << id)) begin
            miscompares++;
            $display("FAIL %s_grant: got %b want %b", nm, req_ready, NREQ'(1) << id);
        end
        @(posedge clk);
        #1 req_valid = '0;
        vectors++;
        if ({rsp_valid, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL %s_exec: got valid/busy=%b%b want 01", nm, rsp_valid, busy);
        end
        @(posedge clk);
        #1;
        got = {rsp_valid, rsp_id, rsp_r, rsp_carry, rsp_zero};
        exp = {1'b1, IDW'(id), er, ec, ez};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s_rsp: got valid=%b id=%0d r=%h c=%b z=%b want valid=1 id=%0d r=%h c=%b z=%b",
                     nm, rsp_valid, rsp_id, rsp_r, rsp_carry, rsp_zero, id, er, ec, ez);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_idle: got valid/busy=%b%b want 00", nm, rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_op[2*i +: 2] = 2'b00;
            req_a[W*i +: W]  = W'(i * 16);
            req_b[W*i +: W]  = 8'h01;
        end
        for (int n = 0; n < 5; n++) begin
            int e;
            e = n % NREQ;
            if (n > 0) @(negedge clk);
            #1;
            vectors++;
            if (req_ready !== (NREQ'(1) << e)) begin
                miscompares++;
                $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, NREQ'(1) << e);
            end
            @(posedge clk);
            @(posedge clk);
            #1;
            vectors++;
            if ({rsp_valid, rsp_id, rsp_r} !== {1'b1, IDW'(e), W'(e * 16 + 1)}) begin
                miscompares++;
                $display("FAIL rr_rsp%0d: got valid=%b id=%0d r=%h want valid=1 id=%0d r=%h",
                         n, rsp_valid, rsp_id, rsp_r, e, W'(e * 16 + 1));
            end
            @(posedge clk);
        end
        #1 req_valid = '0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready     = 1'b0;
        req_valid     = 4'b0100;
        req_op[5:4]   = 2'b00;
        req_a[23:16]  = 8'h07;
        req_b[23:16]  = 8'h08;
        #1;
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL bp_grant: got %b want 0100", req_ready);
        end
        @(posedge clk);
        #1 req_valid = '1;
        @(posedge clk);
        for (int c = 0; c < 6; c++) begin
            #1;
            vectors++;
            if ({rsp_valid, rsp_id, rsp_r, rsp_carry, rsp_zero, req_ready} !==
                {1'b1, 2'd2, 8'h0F, 1'b0, 1'b0, 4'b0000}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got valid=%b id=%0d r=%h c=%b z=%b ready=%b want 1/2/0f/0/0/0000",
                         c, rsp_valid, rsp_id, rsp_r, rsp_carry, rsp_zero, req_ready);
            end
            if (c < 5) @(posedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({rsp_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_release: got valid/busy=%b%b want 00", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_resp();
        @(negedge clk);
        rsp_ready    = 1'b0;
        req_valid    = 4'b0010;
        req_op[3:2]  = 2'b01;
        req_a[15:8]  = 8'h03;
        req_b[15:8]  = 8'h05;
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_r} !== {1'b1, 2'd1, 8'hFE}) begin
            miscompares++;
            $display("FAIL rst_pre: got valid=%b id=%0d r=%h want 1/1/fe", rsp_valid, rsp_id, rsp_r);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({rsp_valid, busy, rsp_id, rsp_r, rsp_carry, rsp_zero} !== 14'h0) begin
            miscompares++;
            $display("FAIL rst_async: got valid=%b busy=%b id=%0d r=%h c=%b z=%b want all 0",
                     rsp_valid, busy, rsp_id, rsp_r, rsp_carry, rsp_zero);
        end
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL rst_ptr: got %b want 0001", req_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        vectors++;
        if ({rsp_valid, rsp_id, rsp_r, rsp_carry} !== {1'b1, 2'd0, 8'h10, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_serve: got valid=%b id=%0d r=%h c=%b want 1/0/10/1",
                     rsp_valid, rsp_id, rsp_r, rsp_carry);
        end
        req_valid = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_op(0, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, "add_ovf");
        test_op(1, 2'b00, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, "add");
        test_op(1, 2'b01, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, "sub_zero");
        test_op(1, 2'b01, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_borrow");
        test_op(2, 2'b10, 8'h81, 8'h01, 8'h02, 1'b1, 1'b0, "shl1");
        test_op(2, 2'b10, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0, "shl0");
        test_op(2, 2'b10, 8'h81, 8'h08, 8'h00, 1'b1, 1'b1, "shl_w");
        test_op(2, 2'b10, 8'h81, 8'h09, 8'h00, 1'b0, 1'b1, "shl_over");
        test_op(3, 2'b11, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, "nand");
        test_op(3, 2'b11, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1, "nand_zero");
        test_backpressure();
        test_reset_mid_resp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
